// File: rtl/rv_g_issue_ctrl.sv
// rv_g_issue_ctrl: in-order issue controller for the RV G core.
// Buffers fetched words, hands the FIFO head to the external decoder, tracks
// in-flight destinations in a scoreboard and issues one hazard-free
// instruction per cycle. An illegal head parks the controller in TRAP until
// a flush.
module rv_g_issue_ctrl #(
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned REG_IDX_W  = 6,
   parameter int unsigned NUM_REGS   = 64
) (
   input  logic                  clk_i,
   input  logic                  arst_ni,
   input  logic                  flush_i,
   // fetch side
   input  logic [31:0]           code_i,
   input  logic                  code_valid_i,
   output logic                  code_ready_o,
   // decoder side
   output logic [31:0]           dec_code_o,
   input  logic [REG_IDX_W-1:0]  dec_rd_i,
   input  logic [REG_IDX_W-1:0]  dec_rs1_i,
   input  logic [REG_IDX_W-1:0]  dec_rs2_i,
   input  logic [REG_IDX_W-1:0]  dec_rs3_i,
   input  logic [3:0]            dec_use_i,
   input  logic                  dec_illegal_i,
   // execute side
   output logic [31:0]           issue_code_o,
   output logic                  issue_valid_o,
   input  logic                  issue_ready_i,
   // writeback
   input  logic                  wb_valid_i,
   input  logic [REG_IDX_W-1:0]  wb_rd_i,
   // status
   output logic                  illegal_o,
   output logic [NUM_REGS-1:0]   busy_o
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

   // dec_use_i bit positions
   localparam int unsigned USE_RD  = 0;
   localparam int unsigned USE_RS1 = 1;
   localparam int unsigned USE_RS2 = 2;
   localparam int unsigned USE_RS3 = 3;

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_TRAP = 1'b1
   } state_e;

   state_e               state_q, state_d;
   logic [31:0]          mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic [NUM_REGS-1:0]  busy_q, busy_d;

   logic                 empty;
   logic                 full;
   logic                 push;
   logic                 pop;
   logic [31:0]          head;
   logic [NUM_REGS-1:0]  wb_mask;
   logic [NUM_REGS-1:0]  busy_eff;
   logic                 hazard;
   logic                 trap_enter;

   // FIFO status derived from the registered occupancy only
   always_comb begin
      empty = (count_q == '0);
      full  = (count_q == CNT_W'(FIFO_DEPTH));
      head  = empty ? 32'h0 : mem_q[rd_ptr_q];
   end

   // Effective busy view: same-cycle writeback bypasses, x0 never busy
   always_comb begin
      wb_mask     = wb_valid_i ? (NUM_REGS'(1) << wb_rd_i) : '0;
      busy_eff    = busy_q & ~wb_mask;
      busy_eff[0] = 1'b0;
   end

   // RAW on any used source, WAW on a used destination
   always_comb begin
      hazard = (dec_use_i[USE_RD]  && busy_eff[dec_rd_i])
            || (dec_use_i[USE_RS1] && busy_eff[dec_rs1_i])
            || (dec_use_i[USE_RS2] && busy_eff[dec_rs2_i])
            || (dec_use_i[USE_RS3] && busy_eff[dec_rs3_i]);
   end

   // Handshakes and externally visible combinational outputs
   always_comb begin
      code_ready_o  = !full && !flush_i;
      push          = code_valid_i && code_ready_o;
      issue_valid_o = (state_q == ST_RUN) && !empty && !hazard
                   && !dec_illegal_i && !flush_i;
      pop           = issue_valid_o && issue_ready_i;
      trap_enter    = (state_q == ST_RUN) && !empty && dec_illegal_i && !flush_i;
      illegal_o     = trap_enter;
      dec_code_o    = head;
      issue_code_o  = head;
      busy_o        = busy_q;
   end

   // FIFO pointer and occupancy next state; flush empties the buffer
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Scoreboard: writeback clears first so an issue-set of the same index wins
   always_comb begin
      busy_d = busy_q;
      if (wb_valid_i) busy_d[wb_rd_i] = 1'b0;
      if (pop && dec_use_i[USE_RD] && (dec_rd_i != '0)) busy_d[dec_rd_i] = 1'b1;
   end

   // Trap FSM next state; flush always returns to RUN
   always_comb begin
      state_d = state_q;
      if (flush_i) begin
         state_d = ST_RUN;
      end else begin
         case (state_q)
            ST_RUN:  if (trap_enter) state_d = ST_TRAP;
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_RUN;
         endcase
      end
   end

   // Control state registers
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         state_q  <= ST_RUN;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         busy_q   <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         busy_q   <= busy_d;
      end
   end

   // Instruction storage
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= 32'h0;
      end else if (push) begin
         mem_q[wr_ptr_q] <= code_i;
      end
   end

endmodule

// File: tb/tb_rv_g_issue_ctrl.sv
// Directed bench for rv_g_issue_ctrl with a tiny decoder model for the
// instruction forms used (OP-IMM, OP, all-zero illegal).
module tb_rv_g_issue_ctrl;

   localparam int unsigned RW = 6;
   localparam int unsigned NR = 64;

   localparam logic [31:0] ADDI_X1_5 = 32'h00500093;
   localparam logic [31:0] ADD_X2    = 32'h00108133;
   localparam logic [31:0] ADDI_X2   = 32'h00100113;
   localparam logic [31:0] ADDI_X3   = 32'h00100193;
   localparam logic [31:0] ADDI_X4   = 32'h00100213;
   localparam logic [31:0] ADDI_X5   = 32'h00100293;

   logic          clk_i = 1'b0;
   logic          arst_ni;
   logic          flush_i;
   logic [31:0]   code_i;
   logic          code_valid_i;
   logic          code_ready_o;
   logic [31:0]   dec_code_o;
   logic [RW-1:0] dec_rd_i, dec_rs1_i, dec_rs2_i, dec_rs3_i;
   logic [3:0]    dec_use_i;
   logic          dec_illegal_i;
   logic [31:0]   issue_code_o;
   logic          issue_valid_o;
   logic          issue_ready_i;
   logic          wb_valid_i;
   logic [RW-1:0] wb_rd_i;
   logic          illegal_o;
   logic [NR-1:0] busy_o;

   int checks = 0;
   int errors = 0;

   rv_g_issue_ctrl #(.FIFO_DEPTH(2), .REG_IDX_W(RW), .NUM_REGS(NR)) dut (
      .clk_i(clk_i), .arst_ni(arst_ni), .flush_i(flush_i),
      .code_i(code_i), .code_valid_i(code_valid_i), .code_ready_o(code_ready_o),
      .dec_code_o(dec_code_o), .dec_rd_i(dec_rd_i), .dec_rs1_i(dec_rs1_i),
      .dec_rs2_i(dec_rs2_i), .dec_rs3_i(dec_rs3_i), .dec_use_i(dec_use_i),
      .dec_illegal_i(dec_illegal_i), .issue_code_o(issue_code_o),
      .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
      .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .illegal_o(illegal_o),
      .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   // Minimal decoder model
   always_comb begin
      dec_rd_i      = {1'b0, dec_code_o[11:7]};
      dec_rs1_i     = {1'b0, dec_code_o[19:15]};
      dec_rs2_i     = {1'b0, dec_code_o[24:20]};
      dec_rs3_i     = '0;
      dec_use_i     = 4'b0000;
      dec_illegal_i = 1'b0;
      case (dec_code_o[6:0])
         7'h13:   dec_use_i = 4'b0011;
         7'h33:   dec_use_i = 4'b0111;
         default: dec_illegal_i = 1'b1;
      endcase
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   initial begin
      arst_ni = 1'b0; flush_i = 1'b0; code_i = '0; code_valid_i = 1'b0;
      issue_ready_i = 1'b0; wb_valid_i = 1'b0; wb_rd_i = '0;
      settle();
      chk("rst_busy", 64'(busy_o), 64'h0);
      chk("rst_ivalid", 64'(issue_valid_o), 64'h0);
      chk("rst_dcode", 64'(dec_code_o), 64'h0);
      chk("rst_illegal", 64'(illegal_o), 64'h0);
      tick(); tick();
      arst_ni = 1'b1;
      settle();
      chk("rel_ready", 64'(code_ready_o), 64'h1);

      // single addi issues one cycle after accept
      issue_ready_i = 1'b1; code_valid_i = 1'b1; code_i = ADDI_X1_5;
      settle();
      chk("t1_ready", 64'(code_ready_o), 64'h1);
      tick();
      code_valid_i = 1'b0;
      settle();
      chk("t1_ivalid", 64'(issue_valid_o), 64'h1);
      chk("t1_icode", 64'(issue_code_o), 64'(ADDI_X1_5));
      tick();
      settle();
      chk("t1_busy", 64'(busy_o), 64'h2);
      chk("t1_empty", 64'(issue_valid_o), 64'h0);
      wb_valid_i = 1'b1; wb_rd_i = 6'd1;
      tick();
      wb_valid_i = 1'b0;
      settle();
      chk("t1_wbclr", 64'(busy_o), 64'h0);

      // RAW stall released by writeback bypass
      code_valid_i = 1'b1; code_i = ADDI_X1_5;
      tick();
      code_i = ADD_X2;
      settle();
      chk("t2_addi_iv", 64'(issue_valid_o), 64'h1);
      tick();
      code_valid_i = 1'b0;
      settle();
      chk("t2_head", 64'(dec_code_o), 64'(ADD_X2));
      chk("t2_stall0", 64'(issue_valid_o), 64'h0);
      tick();
      settle();
      chk("t2_stall1", 64'(issue_valid_o), 64'h0);
      wb_valid_i = 1'b1; wb_rd_i = 6'd1;
      settle();
      chk("t2_bypass", 64'(issue_valid_o), 64'h1);
      tick();
      wb_valid_i = 1'b0;
      settle();
      chk("t2_busy", 64'(busy_o), 64'h4);
      wb_valid_i = 1'b1; wb_rd_i = 6'd2;
      tick();
      wb_valid_i = 1'b0;

      // backpressure: FIFO fills, third word waits for the first pop
      issue_ready_i = 1'b0; code_valid_i = 1'b1; code_i = ADDI_X3;
      settle();
      chk("t3_rdy1", 64'(code_ready_o), 64'h1);
      tick();
      code_i = ADDI_X4;
      settle();
      chk("t3_rdy2", 64'(code_ready_o), 64'h1);
      tick();
      code_i = ADDI_X5;
      settle();
      chk("t3_full", 64'(code_ready_o), 64'h0);
      chk("t3_hold_iv", 64'(issue_valid_o), 64'h1);
      chk("t3_hold_ic", 64'(issue_code_o), 64'(ADDI_X3));
      tick();
      settle();
      chk("t3_full2", 64'(code_ready_o), 64'h0);
      chk("t3_hold_ic2", 64'(issue_code_o), 64'(ADDI_X3));
      issue_ready_i = 1'b1;
      tick();
      settle();
      chk("t3_rdy3", 64'(code_ready_o), 64'h1);
      chk("t3_ic_w4", 64'(issue_code_o), 64'(ADDI_X4));
      chk("t3_iv_w4", 64'(issue_valid_o), 64'h1);
      tick();
      code_valid_i = 1'b0;
      settle();
      chk("t3_ic_w5", 64'(issue_code_o), 64'(ADDI_X5));
      tick();
      settle();
      chk("t3_empty", 64'(issue_valid_o), 64'h0);
      chk("t3_busy", 64'(busy_o), 64'h38);

      // issue-set beats writeback-clear on the same index
      wb_valid_i = 1'b1; wb_rd_i = 6'd3;
      tick();
      wb_rd_i = 6'd4;
      tick();
      wb_valid_i = 1'b0;
      code_valid_i = 1'b1; code_i = ADDI_X5;
      tick();
      code_valid_i = 1'b0;
      settle();
      chk("t5_waw", 64'(issue_valid_o), 64'h0);
      wb_valid_i = 1'b1; wb_rd_i = 6'd5;
      settle();
      chk("t5_bypass", 64'(issue_valid_o), 64'h1);
      tick();
      wb_valid_i = 1'b0;
      settle();
      chk("t5_setwins", 64'(busy_o), 64'h20);
      wb_valid_i = 1'b1; wb_rd_i = 6'd5;
      tick();
      wb_valid_i = 1'b0;
      settle();
      chk("t5_clr", 64'(busy_o), 64'h0);

      // illegal head traps until flush
      code_valid_i = 1'b1; code_i = 32'h0;
      tick();
      code_i = ADDI_X3;
      settle();
      chk("t4_illegal", 64'(illegal_o), 64'h1);
      chk("t4_iv0", 64'(issue_valid_o), 64'h0);
      tick();
      code_valid_i = 1'b0;
      for (int i = 0; i < 10; i++) begin
         settle();
         chk("t4_trap_iv", 64'(issue_valid_o), 64'h0);
         chk("t4_trap_ill", 64'(illegal_o), 64'h0);
         tick();
      end
      flush_i = 1'b1;
      settle();
      chk("t4_fl_rdy", 64'(code_ready_o), 64'h0);
      chk("t4_fl_iv", 64'(issue_valid_o), 64'h0);
      tick();
      flush_i = 1'b0;
      settle();
      chk("t4_post_iv", 64'(issue_valid_o), 64'h0);
      chk("t4_post_dc", 64'(dec_code_o), 64'h0);
      chk("t4_post_rdy", 64'(code_ready_o), 64'h1);
      code_valid_i = 1'b1; code_i = ADDI_X4;
      tick();
      code_valid_i = 1'b0;
      settle();
      chk("t4_run_iv", 64'(issue_valid_o), 64'h1);
      chk("t4_run_ic", 64'(issue_code_o), 64'(ADDI_X4));
      tick();
      wb_valid_i = 1'b1; wb_rd_i = 6'd4;
      tick();
      wb_valid_i = 1'b0;

      // async reset mid-operation
      code_valid_i = 1'b1; code_i = ADDI_X1_5;
      tick();
      code_i = ADDI_X2;
      tick();
      code_valid_i = 1'b0;
      tick();
      issue_ready_i = 1'b0; code_valid_i = 1'b1; code_i = ADDI_X3;
      tick();
      code_i = ADDI_X4;
      tick();
      code_valid_i = 1'b0;
      settle();
      chk("t6_busy", 64'(busy_o), 64'h6);
      chk("t6_head", 64'(dec_code_o), 64'(ADDI_X3));
      chk("t6_full", 64'(code_ready_o), 64'h0);
      arst_ni = 1'b0;
      #1;
      chk("t6_r_busy", 64'(busy_o), 64'h0);
      chk("t6_r_dc", 64'(dec_code_o), 64'h0);
      chk("t6_r_iv", 64'(issue_valid_o), 64'h0);
      chk("t6_r_ill", 64'(illegal_o), 64'h0);
      tick();
      arst_ni = 1'b1;
      settle();
      chk("t6_rel_rdy", 64'(code_ready_o), 64'h1);
      chk("t6_rel_iv", 64'(issue_valid_o), 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
